// File: rtl/player_ctrl.sv
// player_ctrl: moves the player sprite one pixel per video frame.
// Each tick it picks a direction from the keys, asks the map block whether
// the candidate cell is walkable, and commits the move on a free answer.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   state_i               game state (2/4/6 = play stages)
//   tick_i                one-cycle frame pulse
//   key_*_i               level direction keys
//   chk_req_o/x_o/y_o     collision-check request and candidate position
//   chk_ack_i/free_i      map response strobe and walkable flag
//   player_x_o/y_o        committed top-left position
//   player_state_o        sprite index = dir*2 + frame
//   moving_o              last tick produced a committed move
module player_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state_i,
  input  logic       tick_i,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       key_left_i,
  input  logic       key_right_i,
  output logic       chk_req_o,
  output logic [8:0] chk_x_o,
  output logic [8:0] chk_y_o,
  input  logic       chk_ack_i,
  input  logic       chk_free_i,
  output logic [8:0] player_x_o,
  output logic [8:0] player_y_o,
  output logic [3:0] player_state_o,
  output logic       moving_o
);

  localparam int unsigned PW = 9;
  localparam int unsigned GW = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 3;

  localparam logic [PW-1:0] X_MAX    = PW'(310);
  localparam logic [PW-1:0] Y_MAX    = PW'(230);
  localparam logic [TW-1:0] TMO_LAST = TW'(14);
  localparam logic [CW-1:0] STEP_WRAP = CW'(7);

  localparam logic [GW-1:0] ST_STAGE1 = GW'(2);
  localparam logic [GW-1:0] ST_STAGE2 = GW'(4);
  localparam logic [GW-1:0] ST_STAGE3 = GW'(6);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [1:0]    fsm_q, fsm_d;
  logic [GW-1:0] stage_q, stage_d;
  logic [PW-1:0] x_q, x_d, y_q, y_d;
  logic [PW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic          req_q, req_d;
  logic          free_q, free_d;
  logic          moving_q, moving_d;
  logic [1:0]    dir_q, dir_d;
  logic          frame_q, frame_d;
  logic [CW-1:0] step_q, step_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          is_play;
  logic          key_any;
  logic [PW-1:0] spawn_x, spawn_y;
  logic [1:0]    pick_dir;
  logic [PW-1:0] cand_x, cand_y;
  logic          cand_ok;

  // Play-state decode and per-stage spawn point
  always_comb begin
    is_play = 1'b1;
    spawn_x = PW'(20);
    spawn_y = PW'(20);
    case (state_i)
      ST_STAGE1: begin spawn_x = PW'(20);  spawn_y = PW'(20);  end
      ST_STAGE2: begin spawn_x = PW'(20);  spawn_y = PW'(200); end
      ST_STAGE3: begin spawn_x = PW'(150); spawn_y = PW'(110); end
      default:   is_play = 1'b0;
    endcase
  end

  // Direction priority up > down > left > right; bound test precedes the
  // +/-1 so a candidate never wraps
  always_comb begin
    key_any  = key_up_i | key_down_i | key_left_i | key_right_i;
    pick_dir = DIR_DOWN;
    cand_x   = x_q;
    cand_y   = y_q;
    cand_ok  = 1'b0;
    if (key_up_i) begin
      pick_dir = DIR_UP;
      if (y_q != '0) begin
        cand_ok = 1'b1;
        cand_y  = y_q - PW'(1);
      end
    end else if (key_down_i) begin
      pick_dir = DIR_DOWN;
      if (y_q < Y_MAX) begin
        cand_ok = 1'b1;
        cand_y  = y_q + PW'(1);
      end
    end else if (key_left_i) begin
      pick_dir = DIR_LEFT;
      if (x_q != '0) begin
        cand_ok = 1'b1;
        cand_x  = x_q - PW'(1);
      end
    end else if (key_right_i) begin
      pick_dir = DIR_RIGHT;
      if (x_q < X_MAX) begin
        cand_ok = 1'b1;
        cand_x  = x_q + PW'(1);
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    fsm_d    = fsm_q;
    stage_d  = state_i;
    x_d      = x_q;
    y_d      = y_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    req_d    = req_q;
    free_d   = free_q;
    moving_d = moving_q;
    dir_d    = dir_q;
    frame_d  = frame_q;
    step_d   = step_q;
    tmo_d    = tmo_q;

    if (!is_play) begin
      // Non-play abandons any pending check without committing
      fsm_d = S_IDLE;
      req_d = 1'b0;
    end else if (fsm_q == S_IDLE || state_i != stage_q) begin
      // Entering play or switching stage: respawn
      x_d      = spawn_x;
      y_d      = spawn_y;
      req_d    = 1'b0;
      moving_d = 1'b0;
      step_d   = '0;
      tmo_d    = '0;
      fsm_d    = S_WAIT;
    end else begin
      case (fsm_q)
        S_WAIT: begin
          if (tick_i) begin
            if (!key_any) begin
              moving_d = 1'b0;
              frame_d  = 1'b0;
              step_d   = '0;
            end else begin
              dir_d = pick_dir;
              if (cand_ok) begin
                cx_d  = cand_x;
                cy_d  = cand_y;
                req_d = 1'b1;
                tmo_d = '0;
                fsm_d = S_CHECK;
              end else begin
                moving_d = 1'b0;
              end
            end
          end
        end
        S_CHECK: begin
          if (chk_ack_i) begin
            free_d = chk_free_i;
            req_d  = 1'b0;
            fsm_d  = S_UPDATE;
          end else if (tmo_q == TMO_LAST) begin
            free_d = 1'b0;
            req_d  = 1'b0;
            fsm_d  = S_UPDATE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_UPDATE: begin
          if (free_q) begin
            x_d      = cx_q;
            y_d      = cy_q;
            moving_d = 1'b1;
            step_d   = step_q + CW'(1);
            if (step_q == STEP_WRAP) frame_d = ~frame_q;
          end else begin
            moving_d = 1'b0;
            step_d   = '0;
          end
          fsm_d = S_WAIT;
        end
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      stage_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      req_q    <= 1'b0;
      free_q   <= 1'b0;
      moving_q <= 1'b0;
      dir_q    <= DIR_DOWN;
      frame_q  <= 1'b0;
      step_q   <= '0;
      tmo_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      stage_q  <= stage_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      req_q    <= req_d;
      free_q   <= free_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
      frame_q  <= frame_d;
      step_q   <= step_d;
      tmo_q    <= tmo_d;
    end
  end

  assign chk_req_o      = req_q;
  assign chk_x_o        = cx_q;
  assign chk_y_o        = cy_q;
  assign player_x_o     = x_q;
  assign player_y_o     = y_q;
  assign player_state_o = {1'b0, dir_q, frame_q};
  assign moving_o       = moving_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: a frame-level behavioural model
// predicts every output each cycle; directed scenarios pin the model.
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'd4;
  logic       tick = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       chk_ack = 1'b0, chk_free = 1'b0;
  logic       chk_req;
  logic [8:0] chk_x, chk_y, player_x, player_y;
  logic [3:0] player_state;
  logic       moving;

  player_ctrl dut (
    .clk(clk), .rst_n(rst_n), .state_i(state), .tick_i(tick),
    .key_up_i(key_up), .key_down_i(key_down), .key_left_i(key_left),
    .key_right_i(key_right), .chk_req_o(chk_req), .chk_x_o(chk_x),
    .chk_y_o(chk_y), .chk_ack_i(chk_ack), .chk_free_i(chk_free),
    .player_x_o(player_x), .player_y_o(player_y),
    .player_state_o(player_state), .moving_o(moving)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int resp_mode = 0;   // 0 ack free, 1 ack blocked, 2 silent, 3 random
  int req_rises = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x, m_y, m_cx, m_cy, m_dir, m_frame, m_moves, m_moving, m_req;
  int m_pending;   // 0 none, 1 awaiting answer, 2 answer ready
  int m_waited, m_stage;
  bit m_free, m_in_play;

  function automatic bit play_val(input int s);
    return s == 2 || s == 4 || s == 6;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_cx = 0; m_cy = 0; m_dir = 0; m_frame = 0;
    m_moves = 0; m_moving = 0; m_req = 0; m_pending = 0; m_waited = 0;
    m_stage = 0; m_free = 0; m_in_play = 0;
  endtask

  task automatic model_step(input int st, input bit tk, input bit u, input bit d,
                            input bit l, input bit r, input bit ack, input bit fr);
    int dx, dy, nx, ny;
    if (!play_val(st)) begin
      m_in_play = 0; m_req = 0; m_pending = 0;
      return;
    end
    if (!m_in_play || st != m_stage) begin
      m_in_play = 1; m_stage = st; m_req = 0; m_pending = 0;
      m_moving = 0; m_moves = 0;
      case (st)
        2: begin m_x = 20;  m_y = 20;  end
        4: begin m_x = 20;  m_y = 200; end
        default: begin m_x = 150; m_y = 110; end
      endcase
      return;
    end
    if (m_pending == 1) begin
      m_waited++;
      if (ack) begin m_free = fr; m_pending = 2; m_req = 0; end
      else if (m_waited == 15) begin m_free = 0; m_pending = 2; m_req = 0; end
      return;
    end
    if (m_pending == 2) begin
      m_pending = 0;
      if (m_free) begin
        m_x = m_cx; m_y = m_cy; m_moving = 1; m_moves++;
        if (m_moves == 8) begin m_moves = 0; m_frame = 1 - m_frame; end
      end else begin
        m_moving = 0; m_moves = 0;
      end
      return;
    end
    if (!tk) return;
    dx = 0; dy = 0;
    if (u)      begin m_dir = 1; dy = -1; end
    else if (d) begin m_dir = 0; dy = 1;  end
    else if (l) begin m_dir = 2; dx = -1; end
    else if (r) begin m_dir = 3; dx = 1;  end
    else begin m_moving = 0; m_frame = 0; m_moves = 0; return; end
    nx = m_x + dx; ny = m_y + dy;
    if (nx < 0 || nx > 310 || ny < 0 || ny > 230) begin m_moving = 0; return; end
    m_cx = nx; m_cy = ny; m_req = 1; m_pending = 1; m_waited = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(int'(state), tick, key_up, key_down, key_left, key_right,
                    chk_ack, chk_free);
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("player_x", int'(player_x), m_x);
      chk("player_y", int'(player_y), m_y);
      chk("player_state", int'(player_state), m_dir * 2 + m_frame);
      chk("moving", int'(moving), m_moving);
      chk("chk_req", int'(chk_req), m_req);
      if (m_req == 1) begin
        chk("chk_x", int'(chk_x), m_cx);
        chk("chk_y", int'(chk_y), m_cy);
      end
      if (chk_req && !req_prev) req_rises++;
    end
    req_prev = chk_req;
  end

  // ---------------- map-block responder ----------------
  always @(negedge clk) begin
    case (resp_mode)
      0: begin chk_ack = chk_req; chk_free = 1'b1; end
      1: begin chk_ack = chk_req; chk_free = 1'b0; end
      2: begin chk_ack = 1'b0;    chk_free = 1'b0; end
      default: begin
        chk_ack  = chk_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
        chk_free = 1'($urandom_range(0, 1));
      end
    endcase
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ticks(input int n, input int gap);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      wait_cycles(gap);
    end
  endtask

  task automatic set_keys(input bit u, input bit d, input bit l, input bit r);
    key_up = u; key_down = d; key_left = l; key_right = r;
  endtask

  int ps_hist [1:16];
  int states_pool [5] = '{2, 4, 6, 0, 1};

  initial begin
    // Reset with STAGE2 already selected; spawn on the first edge
    wait_cycles(2);
    chk("rst_x", int'(player_x), 0);
    chk("rst_y", int'(player_y), 0);
    chk("rst_ps", int'(player_state), 0);
    chk("rst_req", int'(chk_req), 0);
    #2 rst_n = 1'b1;
    wait_cycles(1);
    chk("spawn2_x", int'(player_x), 20);
    chk("spawn2_y", int'(player_y), 200);

    // Three free moves right
    set_keys(0, 0, 0, 1);
    do_ticks(3, 8);
    chk("right3_x", int'(player_x), 23);
    chk("right3_y", int'(player_y), 200);
    chk("right3_ps", int'(player_state), 6);
    chk("right3_moving", int'(moving), 1);

    // STAGE1 spawn, run up into the top edge
    set_keys(0, 0, 0, 0);
    state = 4'd2;
    wait_cycles(2);
    chk("spawn1_x", int'(player_x), 20);
    chk("spawn1_y", int'(player_y), 20);
    set_keys(1, 0, 0, 0);
    do_ticks(20, 6);
    chk("top_y", int'(player_y), 0);
    req_rises = 0;
    do_ticks(5, 6);
    chk("top_no_req", req_rises, 0);
    chk("top_y_hold", int'(player_y), 0);
    chk("top_moving", int'(moving), 0);

    // Run right into the x=310 edge
    set_keys(0, 0, 0, 1);
    do_ticks(290, 5);
    chk("right_edge_x", int'(player_x), 310);
    req_rises = 0;
    do_ticks(3, 5);
    chk("right_no_req", req_rises, 0);
    chk("right_x_hold", int'(player_x), 310);

    // Blocked move left
    set_keys(0, 0, 0, 0);
    do_ticks(1, 5);
    set_keys(0, 0, 1, 0);
    resp_mode = 1;
    do_ticks(1, 8);
    chk("blocked_x", int'(player_x), 310);
    chk("blocked_moving", int'(moving), 0);
    chk("blocked_ps", int'(player_state), 4);

    // Timeout: request stays up 15 cycles then drops
    resp_mode = 2;
    do_ticks(1, 0);
    wait_cycles(13);
    chk("tmo_req_held", int'(chk_req), 1);
    wait_cycles(2);
    chk("tmo_req_drop", int'(chk_req), 0);
    wait_cycles(4);
    chk("tmo_x", int'(player_x), 310);
    resp_mode = 0;
    do_ticks(1, 8);
    chk("after_tmo_x", int'(player_x), 309);

    // Leave play mid-check
    resp_mode = 2;
    do_ticks(1, 2);
    chk("midchk_req", int'(chk_req), 1);
    state = 4'd0;
    wait_cycles(1);
    chk("title_req", int'(chk_req), 0);
    wait_cycles(5);
    chk("title_x", int'(player_x), 309);
    state = 4'd2;
    wait_cycles(2);
    chk("respawn_x", int'(player_x), 20);
    chk("respawn_y", int'(player_y), 20);

    // Frame toggles every 8 committed moves
    resp_mode = 0;
    set_keys(0, 0, 0, 0);
    do_ticks(1, 5);
    set_keys(0, 1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      do_ticks(1, 6);
      ps_hist[i] = int'(player_state);
    end
    chk("frame_m7", ps_hist[7], 0);
    chk("frame_m8", ps_hist[8], 1);
    chk("frame_m15", ps_hist[15], 1);
    chk("frame_m16", ps_hist[16], 0);
    chk("down16_y", int'(player_y), 36);

    // Randomized play
    resp_mode = 3;
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 4) == 0);
      set_keys($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 249) == 0)
        state = 4'(states_pool[$urandom_range(0, 4)]);
      @(negedge clk);
    end
    tick = 1'b0;

    // Async reset mid-check clears outputs immediately
    state = 4'd6;
    resp_mode = 2;
    set_keys(0, 0, 1, 0);
    wait_cycles(3);
    do_ticks(1, 2);
    chk("pre_rst_req", int'(chk_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(player_x), 0);
    chk("arst_y", int'(player_y), 0);
    chk("arst_ps", int'(player_state), 0);
    chk("arst_moving", int'(moving), 0);
    chk("arst_req", int'(chk_req), 0);
    chk("arst_cx", int'(chk_x), 0);
    chk("arst_cy", int'(chk_y), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cycles(2);
    chk("spawn3_x", int'(player_x), 150);
    chk("spawn3_y", int'(player_y), 110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 state  input  4  game state; STAGE1=2, STAGE2=4, STAGE3=6; all other values are non-play states.
REQ-004 tick  input  1  one-cycle frame pulse, one per video frame.
REQ-005 key_up, key_down, key_left, key_right  input  1 each  level-sensitive direction keys.
REQ-006 chk_req  output  1  collision-check request to the map block.
REQ-007 chk_x, chk_y  output  9 each  candidate top-left position under check.
REQ-008 chk_ack  input  1  one-cycle response strobe from the map block.
REQ-009 chk_free  input  1  sampled with chk_ack; 1 = candidate cell is walkable.
REQ-010 player_x, player_y  output  9 each  player top-left in 320x240 half-resolution space.
REQ-011 player_state  output  4  sprite frame index for the player renderer.
REQ-012 moving  output  1  high while the last tick produced a committed move.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_TICK, CHECK, UPDATE.
REQ-014 IDLE: entered when state is non-play; outputs hold; on any play state -> load spawn, go WAIT_TICK.
REQ-015 Spawn positions SHALL be: STAGE1 (20,20); STAGE2 (20,200); STAGE3 (150,110).
REQ-016 A change between two play-state values SHALL reload that stage's spawn in the next cycle, from any FSM state.
REQ-017 WAIT_TICK: on tick, pick one direction by priority up > down > left > right.
REQ-018 Only one axis SHALL move per tick.
REQ-019 Candidate position = current position ±1 pixel on the chosen axis.
REQ-020 Bounds SHALL be x 0..310 and y 0..230.
REQ-021 A candidate outside bounds, or no key pressed, SHALL cause no move: clear moving, stay in WAIT_TICK, issue no request.
REQ-022 Otherwise the FSM SHALL go to CHECK and drive chk_req=1 with chk_x/chk_y held stable until chk_ack or timeout.
REQ-023 chk_ack SHALL be accepted from the cycle after chk_req rises.
REQ-024 CHECK SHALL time out after 15 cycles without chk_ack; a timeout counts as blocked.
REQ-025 chk_req SHALL drop in the cycle after chk_ack or after the timeout.
REQ-026 UPDATE (one cycle): if free, commit the candidate, set moving=1, and advance the step counter; if blocked, keep position, set moving=0, and reset the step counter. The FSM then returns to WAIT_TICK.
REQ-027 player_state = dir*2 + frame, with dir down=0, up=1, left=2, right=3.
REQ-028 dir SHALL update to the chosen direction even when the move is blocked.
REQ-029 frame SHALL toggle after every 8 committed moves (3-bit step counter wrap); frame=0 whenever no key is pressed at a tick.
REQ-030 A tick arriving during CHECK or UPDATE SHALL be ignored; it is not queued.
REQ-031 Leaving play state mid-CHECK SHALL drop chk_req in the next cycle and enter IDLE with no commit.
REQ-032 Position arithmetic SHALL be 9-bit unsigned; bounds are checked before subtraction so no wrap can occur.

Reset
REQ-033 While rst_n=0: FSM=IDLE, player_x=0, player_y=0, player_state=0, moving=0, chk_req=0, chk_x=0, chk_y=0, step counter=0, timeout counter=0.
REQ-034 Deasserting rst_n with state already in a play state SHALL load spawn on the first clock edge.

Verification
REQ-035 state=STAGE2 after reset, key_right held, map always free, 3 ticks -> (20,200) becomes (23,200); player_state=6 (dir right, frame 0).
REQ-036 At STAGE1 spawn, key_up held, 25 ticks, map free -> player_y stops at 0 and no chk_req is issued once at the edge; x=310 with key_right behaves likewise.
REQ-037 chk_free=0 on the ack for key_left -> position unchanged, moving=0, player_state=4.
REQ-038 No chk_ack for 15 cycles -> chk_req drops, position unchanged, FSM back in WAIT_TICK.
REQ-039 state switches from STAGE1 to TITLE while chk_req=1 -> chk_req=0 next cycle, and the position does not change afterward.
REQ-040 key_down held and map free for 16 ticks -> frame toggles at moves 8 and 16 (player_state 0->1->0); rst_n pulsed mid-CHECK -> all outputs 0 immediately.
